ifft4_2d: RTL and testbench

- Inverse counterpart of the team's 4x4 two-dimensional FFT. Takes a frequency-domain 4x4 complex tile, as produced by the forward 2D FFT, and returns the spatial-domain tile scaled by 1/16.
- Fully pipelined: row IFFT, then column IFFT, then scale/round/saturate. Accepts one tile per clock.
- Sits after the pointwise-multiply stage of the FFT-based convolution datapath.

---
 rtl/ifft4_2d_pkg.sv | 41 ++++
 rtl/ifft4_2d_ifft4_1d.sv | 43 ++++
 rtl/ifft4_2d.sv | 190 +++++++++++++++++++
 tb/tb_ifft4_2d.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifft4_2d_pkg.sv
// Shared types and helpers for the 4x4 2D IFFT datapath.
//   complex_t  : DATA_W-bit signed re/im sample
//   cplx_ext_t : DATA_W+4-bit sample, full-precision output of the column pass
//   tile_t     : 4x4 tile of complex_t, indexed [row][col]
//   IFFT_LAT   : input-strobe to output-strobe latency in cycles
//   sat_to_data / is_sat : clamp a widened value to DATA_W and detect clamping
package ifft4_2d_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned EXT_W    = DATA_W + 4;
    localparam int unsigned IFFT_LAT = 3;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_t;

    typedef struct packed {
        logic signed [EXT_W-1:0] re;
        logic signed [EXT_W-1:0] im;
    } cplx_ext_t;

    typedef complex_t [0:3][0:3] tile_t;

    localparam logic signed [DATA_W-1:0] DATA_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] DATA_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic is_sat(input logic signed [EXT_W:0] x);
        return (x > (EXT_W+1)'(DATA_MAX)) || (x < (EXT_W+1)'(DATA_MIN));
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_to_data(input logic signed [EXT_W:0] x);
        if (x > (EXT_W+1)'(DATA_MAX)) begin
            return DATA_MAX;
        end else if (x < (EXT_W+1)'(DATA_MIN)) begin
            return DATA_MIN;
        end
        return x[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/ifft4_2d_ifft4_1d.sv
// Combinational 4-point inverse DFT butterfly: y[n] = sum_k x[k] * (+j)^(k*n).
// Multiplication by +/-j is a re/im swap with a sign flip, so only adders are used.
//   re_i/im_i : four IN_W-bit signed inputs
//   re_o/im_o : four IN_W+2-bit signed outputs (no overflow possible)
module ifft4_1d #(
    parameter int unsigned IN_W = 16
) (
    input  logic signed [IN_W-1:0] re_i [4],
    input  logic signed [IN_W-1:0] im_i [4],
    output logic signed [IN_W+1:0] re_o [4],
    output logic signed [IN_W+1:0] im_o [4]
);

    logic signed [IN_W+1:0] x_re [4];
    logic signed [IN_W+1:0] x_im [4];
    logic signed [IN_W+1:0] a_re, a_im, b_re, b_im, c_re, c_im, d_re, d_im;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x_re[i] = (IN_W+2)'(re_i[i]);
            x_im[i] = (IN_W+2)'(im_i[i]);
        end
        a_re = x_re[0] + x_re[2];
        a_im = x_im[0] + x_im[2];
        b_re = x_re[0] - x_re[2];
        b_im = x_im[0] - x_im[2];
        c_re = x_re[1] + x_re[3];
        c_im = x_im[1] + x_im[3];
        d_re = x_re[1] - x_re[3];
        d_im = x_im[1] - x_im[3];

        re_o[0] = a_re + c_re;
        im_o[0] = a_im + c_im;
        re_o[2] = a_re - c_re;
        im_o[2] = a_im - c_im;
        // y1 = b + j*d, y3 = b - j*d
        re_o[1] = b_re - d_im;
        im_o[1] = b_im + d_re;
        re_o[3] = b_re + d_im;
        im_o[3] = b_im - d_re;
    end

endmodule

// File: rtl/ifft4_2d.sv
// Pipelined 4x4 2D inverse FFT with 1/16 scaling. One tile per clock, 3-cycle latency.
// Stage 1: row transforms (DATA_W+2), stage 2: column transforms (DATA_W+4, full
// precision), stage 3: arithmetic shift by 4 and saturation to DATA_W.
//   clk_i       : clock
//   rst_ni      : asynchronous active-low reset, clears all state
//   next_i      : strobe, in_i valid this cycle
//   in_i        : frequency tile [k][l]
//   out_o       : spatial tile [m][n], holds when next_out_o is low
//   next_out_o  : strobe, out_o valid this cycle
//   busy_o      : any stage holds a valid tile
//   sat_flag_o  : sticky saturation flag (only with IFFT4_2D_ROUND_EN)
// Build option IFFT4_2D_ROUND_EN: round half up before the shift and add sat_flag_o.
module ifft4_2d
    import ifft4_2d_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  next_i,
    input  tile_t in_i,
    output tile_t out_o,
    output logic  next_out_o,
    output logic  busy_o
`ifdef IFFT4_2D_ROUND_EN
    ,
    output logic  sat_flag_o
`endif
);

    localparam int unsigned S1_W = DATA_W + 2;
    localparam int unsigned S2_W = DATA_W + 4;

    logic [IFFT_LAT-1:0] valid_q, valid_d;

    logic signed [DATA_W-1:0] row_re [4][4];
    logic signed [DATA_W-1:0] row_im [4][4];
    logic signed [S1_W-1:0]   s1_re_d [4][4];
    logic signed [S1_W-1:0]   s1_im_d [4][4];
    logic signed [S1_W-1:0]   s1_re_q [4][4];
    logic signed [S1_W-1:0]   s1_im_q [4][4];
    logic signed [S1_W-1:0]   col_re [4][4];
    logic signed [S1_W-1:0]   col_im [4][4];
    logic signed [S2_W-1:0]   s2_re_d [4][4];
    logic signed [S2_W-1:0]   s2_im_d [4][4];
    cplx_ext_t                s2_q [4][4];
    tile_t                    out_d, out_q;

    // Widen, optionally add the rounding bias, then floor-divide by 16.
    function automatic logic signed [S2_W:0] shift_round(input logic signed [S2_W-1:0] x);
        logic signed [S2_W:0] xe;
        xe = (S2_W+1)'(x);
`ifdef IFFT4_2D_ROUND_EN
        xe = xe + (S2_W+1)'(8);
`endif
        return xe >>> 4;
    endfunction

    // Valid shift register: bit i marks stage i+1 as occupied.
    assign valid_d    = {valid_q[IFFT_LAT-2:0], next_i};
    assign next_out_o = valid_q[IFFT_LAT-1];
    assign busy_o     = |valid_q;
    assign out_o      = out_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Stage 1: transform along l for every row k.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                row_re[k][l] = in_i[k][l].re;
                row_im[k][l] = in_i[k][l].im;
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_row
        ifft4_1d #(
            .IN_W (DATA_W)
        ) u_row (
            .re_i (row_re[k]),
            .im_i (row_im[k]),
            .re_o (s1_re_d[k]),
            .im_o (s1_im_d[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < 4; k++) begin
                for (int n = 0; n < 4; n++) begin
                    s1_re_q[k][n] <= '0;
                    s1_im_q[k][n] <= '0;
                end
            end
        end else if (next_i) begin
            s1_re_q <= s1_re_d;
            s1_im_q <= s1_im_d;
        end
    end

    // Stage 2: transpose so each instance sees one column, then transform along k.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 4; k++) begin
                col_re[n][k] = s1_re_q[k][n];
                col_im[n][k] = s1_im_q[k][n];
            end
        end
    end

    for (genvar n = 0; n < 4; n++) begin : g_col
        ifft4_1d #(
            .IN_W (S1_W)
        ) u_col (
            .re_i (col_re[n]),
            .im_i (col_im[n]),
            .re_o (s2_re_d[n]),
            .im_o (s2_im_d[n])
        );
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    s2_q[m][n] <= '0;
                end
            end
        end else if (valid_q[0]) begin
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    s2_q[m][n].re <= s2_re_d[n][m];
                    s2_q[m][n].im <= s2_im_d[n][m];
                end
            end
        end
    end

    // Stage 3: scale and saturate.
    always_comb begin
        out_d = '0;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                out_d[m][n].re = sat_to_data(shift_round(s2_q[m][n].re));
                out_d[m][n].im = sat_to_data(shift_round(s2_q[m][n].im));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_q <= '0;
        end else if (valid_q[1]) begin
            out_q <= out_d;
        end
    end

`ifdef IFFT4_2D_ROUND_EN
    logic sat_any;
    logic sat_flag_q;

    always_comb begin
        sat_any = 1'b0;
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                sat_any = sat_any | is_sat(shift_round(s2_q[m][n].re))
                                  | is_sat(shift_round(s2_q[m][n].im));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sat_flag_q <= 1'b0;
        end else if (valid_q[1] && sat_any) begin
            sat_flag_q <= 1'b1;
        end
    end

    assign sat_flag_o = sat_flag_q;
`endif

endmodule

// File: tb/tb_ifft4_2d.sv
// Directed self-checking bench for ifft4_2d: impulse/flat/single-bin tiles, a
// back-to-back round trip through a forward 2D FFT model, mid-flight reset and
// the saturation corner. Build with IFFT4_2D_ROUND_EN to cover the rounding mode.
module tb_ifft4_2d;
    import ifft4_2d_pkg::*;

    logic  clk_i = 1'b0;
    logic  rst_ni;
    logic  next_i;
    tile_t in_i;
    tile_t out_o;
    logic  next_out_o;
    logic  busy_o;
`ifdef IFFT4_2D_ROUND_EN
    logic  sat_flag_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ifft4_2d #(
        .DATA_W (16)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .next_i     (next_i),
        .in_i       (in_i),
        .out_o      (out_o),
        .next_out_o (next_out_o),
        .busy_o     (busy_o)
`ifdef IFFT4_2D_ROUND_EN
        ,
        .sat_flag_o (sat_flag_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic complex_t cx(input int re, input int im);
        complex_t c;
        c.re = 16'(re);
        c.im = 16'(im);
        return c;
    endfunction

    task automatic check_tile(input string tag, input tile_t got, input tile_t exp);
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                check_eq($sformatf("%s[%0d][%0d]", tag, m, n), got[m][n], exp[m][n]);
            end
        end
    endtask

    // Unscaled forward 2D DFT with W = -j.
    function automatic tile_t fft2d(input tile_t x);
        tile_t f;
        int sr, si, ar, ai, p;
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                sr = 0;
                si = 0;
                for (int m = 0; m < 4; m++) begin
                    for (int n = 0; n < 4; n++) begin
                        ar = $signed(x[m][n].re);
                        ai = $signed(x[m][n].im);
                        p  = (k * m + l * n) % 4;
                        case (p)
                            0: begin sr += ar; si += ai; end
                            1: begin sr += ai; si -= ar; end
                            2: begin sr -= ar; si -= ai; end
                            default: begin sr -= ai; si += ar; end
                        endcase
                    end
                end
                f[k][l] = cx(sr, si);
            end
        end
        return f;
    endfunction

    // Drive one tile, wait for its strobe (bounded), return result and latency.
    task automatic send_tile(input tile_t t, output tile_t res, output int lat);
        @(negedge clk_i);
        in_i   = t;
        next_i = 1'b1;
        @(negedge clk_i);
        next_i = 1'b0;
        lat    = 1;
        while (!next_out_o && lat < 10) begin
            @(negedge clk_i);
            lat++;
        end
        res = out_o;
    endtask

    initial begin
        tile_t t, r, e;
        tile_t orig [5];
        tile_t freq [5];
        int    lat;

        rst_ni = 1'b0;
        next_i = 1'b0;
        in_i   = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_next_out", 32'(next_out_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_out00", out_o[0][0], 32'd0);
`ifdef IFFT4_2D_ROUND_EN
        check_eq("rst_sat_flag", 32'(sat_flag_o), 32'd0);
`endif
        rst_ni = 1'b1;

        // 1: DC impulse -> every output 1+0j, latency 3, single-cycle strobe, hold.
        t = '0;
        t[0][0] = cx(16, 0);
        for (int m = 0; m < 4; m++)
            for (int n = 0; n < 4; n++) e[m][n] = cx(1, 0);
        send_tile(t, r, lat);
        check_eq("dc_latency", lat, 32'd3);
        check_eq("dc_strobe", 32'(next_out_o), 32'd1);
        check_tile("dc", r, e);
        @(negedge clk_i);
        check_eq("dc_strobe_drop", 32'(next_out_o), 32'd0);
        check_eq("dc_hold", out_o[2][3], cx(1, 0));
        check_eq("dc_idle_busy", 32'(busy_o), 32'd0);

        // 2: flat spectrum -> only out[0][0] = 16.
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++) t[k][l] = cx(16, 0);
        e = '0;
        e[0][0] = cx(16, 0);
        send_tile(t, r, lat);
        check_eq("flat_latency", lat, 32'd3);
        check_tile("flat", r, e);

        // 3: single bin in[0][1] -> j^n along every row.
        t = '0;
        t[0][1] = cx(16, 0);
        for (int m = 0; m < 4; m++) begin
            e[m][0] = cx(1, 0);
            e[m][1] = cx(0, 1);
            e[m][2] = cx(-1, 0);
            e[m][3] = cx(0, -1);
        end
        send_tile(t, r, lat);
        check_eq("bin_latency", lat, 32'd3);
        check_tile("bin", r, e);

        // 4: five back-to-back round-trip tiles.
        for (int i = 0; i < 5; i++) begin
            for (int m = 0; m < 4; m++)
                for (int n = 0; n < 4; n++)
                    orig[i][m][n] = cx(int'($urandom_range(0, 1023)) - 512,
                                       int'($urandom_range(0, 1023)) - 512);
            freq[i] = fft2d(orig[i]);
        end
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_i);
            if (i >= 1)
                check_eq($sformatf("b2b_busy_c%0d", i), 32'(busy_o), (i <= 7) ? 32'd1 : 32'd0);
            check_eq($sformatf("b2b_strobe_c%0d", i), 32'(next_out_o),
                     (i >= 3 && i <= 7) ? 32'd1 : 32'd0);
            if (i >= 3 && i <= 7)
                check_tile($sformatf("b2b_tile%0d", i - 3), out_o, orig[i-3]);
            if (i < 5) begin
                in_i   = freq[i];
                next_i = 1'b1;
            end else begin
                next_i = 1'b0;
            end
        end

        // 5: reset mid-flight discards two in-flight tiles.
        t = '0;
        t[0][0] = cx(16, 0);
        @(negedge clk_i);
        in_i   = t;
        next_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        next_i = 1'b0;
        rst_ni = 1'b0;
        #1;
        check_eq("mrst_busy_now", 32'(busy_o), 32'd0);
        check_eq("mrst_strobe_now", 32'(next_out_o), 32'd0);
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk_i);
            check_eq($sformatf("mrst_strobe_t%0d", c), 32'(next_out_o), 32'd0);
            check_eq($sformatf("mrst_busy_t%0d", c), 32'(busy_o), 32'd0);
            check_eq($sformatf("mrst_out00_t%0d", c), out_o[0][0], 32'd0);
            check_eq($sformatf("mrst_out33_t%0d", c), out_o[3][3], 32'd0);
            if (c == 3) rst_ni = 1'b1;
        end

        // 6: saturation corner, out[2][2] pre-scale sum is 524280.
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < 4; l++)
                t[k][l] = ((k + l) % 2 == 0) ? cx(32767, 0) : cx(-32768, 0);
`ifdef IFFT4_2D_ROUND_EN
        check_eq("sat_flag_before", 32'(sat_flag_o), 32'd0);
`endif
        send_tile(t, r, lat);
        check_eq("sat_latency", lat, 32'd3);
        check_eq("sat_out22", r[2][2], cx(32767, 0));
`ifdef IFFT4_2D_ROUND_EN
        check_eq("sat_out00", r[0][0], cx(0, 0));
        check_eq("sat_flag_rise", 32'(sat_flag_o), 32'd1);
        repeat (3) @(negedge clk_i);
        check_eq("sat_flag_sticky", 32'(sat_flag_o), 32'd1);
`else
        check_eq("sat_out00", r[0][0], cx(-1, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
